conv_encoder_par: RTL and testbench
===================================

CONV_ENCODER_PAR -- requirements
Module: conv_encoder_par

Interface
REQ-001 SHALL have parameter K, default 3: constraint length, legal range 2..9.
REQ-002 SHALL have parameter N, default 2: symbols emitted per input bit, legal range 2..4.
REQ-003 SHALL have parameter G, default {3'b011, 3'b111}: N*K-bit packed generators; G[j] occupies bits j*K+K-1..j*K; bit i of G[j] taps sr[i].
REQ-004 SHALL have port clock, input, 1: rising-edge clock (reset: reset, asynchronous, active-low; clock: clock).
REQ-005 SHALL have port reset, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port in_valid, input, 1: in_bit/in_last present.
REQ-007 SHALL have port in_ready, output, 1: encoder accepts an input bit this cycle.
REQ-008 SHALL have port in_bit, input, 1: data bit.
REQ-009 SHALL have port in_last, input, 1: final bit of block; triggers tail flush.
REQ-010 SHALL have port out_valid, output, 1: out_bit holds a valid symbol.
REQ-011 SHALL have port out_ready, input, 1: sink consumes the symbol.
REQ-012 SHALL have port out_bit, output, 1: coded symbol.
REQ-013 SHALL have port out_last, output, 1: final symbol of terminated block.
REQ-014 SHALL have port busy, output, 1: state is not IDLE.

Function
REQ-015 SHALL hold shift register sr[K-1:0], sr[0] newest; on accept (in_valid && in_ready) it SHALL load sr <= {sr[K-2:0], in_bit}.
REQ-016 SHALL compute symbol j as the XOR-reduction of (sr_new & G[j]), all N symbols latched into a symbol register on the accepting edge.
REQ-017 SHALL emit symbols in order j = 0..N-1, one per out_valid && out_ready handshake, tracked by a phase counter that wraps from N-1 to 0.
REQ-018 SHALL implement FSM IDLE -> EMIT (on accept) -> IDLE (phase N-1 consumed, no refill), EMIT -> FLUSH (phase N-1 consumed, block's in_last seen), and FLUSH -> IDLE (last tail symbol consumed).
REQ-019 SHALL drive in_ready = 1 in IDLE, and in EMIT only when phase == N-1 && out_ready && last-flag clear; 0 in FLUSH and during reset.
REQ-020 SHALL assert out_valid the cycle after an accept (latency 1) and keep out_valid, out_bit, and out_last stable while out_ready is 0.
REQ-021 SHALL sustain one input bit per N cycles with in_valid and out_ready held at 1 (no bubble between groups).
REQ-022 SHALL shift K-1 zero bits in FLUSH, emitting N symbols each, generated internally without an input handshake.
REQ-023 SHALL assert out_last only on symbol N-1 of the final tail bit; sr SHALL be all-zero after that handshake.
REQ-024 SHALL carry sr across blocks without flush when in_last = 0 (continuous stream mode).
REQ-025 SHALL ignore in_bit and in_last while in_ready = 0.

Reset
REQ-026 SHALL, on reset low, immediately clear sr, symbol register, phase, tail counter, and last-flag, set state IDLE, and drive out_valid = 0, out_last = 0, out_bit = 0, busy = 0.
REQ-027 SHALL, on reset asserted mid-EMIT or mid-FLUSH, abandon pending symbols; the first block after release SHALL encode from the all-zero state.

Structure
REQ-028 SHALL take the state enum (IDLE, EMIT, FLUSH) and the default generator constants from package conv_pkg.
REQ-029 SHALL instantiate sub-module conv_parity (K-bit masked XOR reduction), one per generator.
REQ-030 SHALL include elaboration-time checks rejecting K or N outside their legal ranges.

Verification (K=3, N=2, default G)
REQ-031 SHALL cover: bits 1, 0, 1 (last on third), out_ready = 1 -> out_bit sequence 1,1,1,1,0,1,1,1,1,0, with out_last only on the 10th symbol and busy low after it.
REQ-032 SHALL cover: continuous stream 1,1,1,1 with in_last = 0 -> 1,1,0,0,1,0,1,0, with in_ready high every 2nd cycle and no flush.
REQ-033 SHALL cover: out_ready low for 5 cycles on the 2nd symbol -> out_bit and out_valid held, in_ready 0, and no symbol lost or duplicated.
REQ-034 SHALL cover: reset asserted during FLUSH -> outputs 0 immediately; next bit 1 -> symbols 1,1.
REQ-035 SHALL cover: in_valid toggled while in_ready = 0 -> no sr change, and the output stream equals the reference model output.
REQ-036 SHALL cover: K=5, N=3, random generators, and 1000 random bits against a scoreboard model -> bit-exact match including tail and out_last.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and constants for the parallel-output convolutional encoder.
package conv_pkg;

    // Encoder control states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EMIT  = 2'd1,
        ST_FLUSH = 2'd2
    } conv_state_e;

    // Legal parameter ranges
    localparam int CONV_K_MIN = 2;
    localparam int CONV_K_MAX = 9;
    localparam int CONV_N_MIN = 2;
    localparam int CONV_N_MAX = 4;

    // Default code: K=3, rate 1/2, G[1]=3'b011, G[0]=3'b111
    localparam int CONV_DEFAULT_K = 3;
    localparam int CONV_DEFAULT_N = 2;
    localparam logic [5:0] CONV_DEFAULT_G = {3'b011, 3'b111};

    // Width of a counter that must hold values 0..count-1 (never zero width)
    function automatic int conv_cntr_width(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/conv_parity.sv
// One generator tap: XOR reduction of the shift register masked by the generator.
module conv_parity #(
    parameter int K = 3
) (
    input  logic [K-1:0] data,
    input  logic [K-1:0] mask,
    output logic         parity
);

    assign parity = ^(data & mask);

endmodule

// File: rtl/conv_encoder_par.sv
// Convolutional encoder: one input bit in, N coded symbols out serially,
// with an optional K-1 zero-bit tail flush terminating each block.
module conv_encoder_par
    import conv_pkg::*;
#(
    parameter int             K = CONV_DEFAULT_K,
    parameter int             N = CONV_DEFAULT_N,
    parameter logic [N*K-1:0] G = CONV_DEFAULT_G
) (
    input  logic clock,
    input  logic reset,
    input  logic in_valid,
    output logic in_ready,
    input  logic in_bit,
    input  logic in_last,
    output logic out_valid,
    input  logic out_ready,
    output logic out_bit,
    output logic out_last,
    output logic busy
);

    localparam int PW = conv_cntr_width(N);
    localparam int TW = conv_cntr_width(K - 1);
    localparam logic [PW-1:0] PHASE_LAST = PW'(N - 1);
    localparam logic [TW-1:0] TAIL_LAST  = TW'(K - 2);

    // Reject illegal code shapes at elaboration
    generate
        if (K < CONV_K_MIN || K > CONV_K_MAX) begin : g_bad_k
            $error("conv_encoder_par: K=%0d outside legal range 2..9", K);
        end
        if (N < CONV_N_MIN || N > CONV_N_MAX) begin : g_bad_n
            $error("conv_encoder_par: N=%0d outside legal range 2..4", N);
        end
    endgenerate

    conv_state_e   state_q, state_d;
    logic [K-1:0]  sr_q, sr_d;
    logic [N-1:0]  sym_q, sym_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [TW-1:0] tail_q, tail_d;
    logic          last_q, last_d;
    logic          out_valid_q, out_valid_d;
    logic          out_bit_q, out_bit_d;
    logic          out_last_q, out_last_d;

    logic          in_ready_c;
    logic          accept;
    logic          out_fire;
    logic          shift_bit;
    logic [K-1:0]  sr_shift;
    logic [N-1:0]  par;

    // Input readiness: always in IDLE, on the final symbol of a group in
    // EMIT when the sink takes it and no flush is pending, never in FLUSH
    always_comb begin
        in_ready_c = 1'b0;
        case (state_q)
            ST_IDLE:  in_ready_c = 1'b1;
            ST_EMIT:  in_ready_c = (phase_q == PHASE_LAST) && out_ready && !last_q;
            default:  in_ready_c = 1'b0;
        endcase
    end

    // Reset low forces in_ready low even though the state already reads IDLE
    assign in_ready = in_ready_c & reset;
    assign accept   = in_valid & in_ready;
    assign out_fire = out_valid_q & out_ready;

    // The candidate shifted register: the input bit on accept, zero for tail bits
    assign shift_bit = accept & in_bit;
    assign sr_shift  = {sr_q[K-2:0], shift_bit};

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_par
            conv_parity #(
                .K(K)
            ) u_parity (
                .data  (sr_shift),
                .mask  (G[gi*K +: K]),
                .parity(par[gi])
            );
        end
    endgenerate

    // Next-state logic for control, shift register, symbols and outputs
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        sym_d   = sym_q;
        phase_d = phase_q;
        tail_d  = tail_q;
        last_d  = last_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_EMIT;
                    sr_d    = sr_shift;
                    sym_d   = par;
                    phase_d = '0;
                    last_d  = in_last;
                end
            end

            ST_EMIT: begin
                if (out_fire) begin
                    if (phase_q != PHASE_LAST) begin
                        phase_d = phase_q + PW'(1);
                    end else if (accept) begin
                        // Back-to-back refill: next group starts without a bubble
                        sr_d    = sr_shift;
                        sym_d   = par;
                        phase_d = '0;
                        last_d  = in_last;
                    end else if (last_q) begin
                        // Block ended: shift in the first zero tail bit
                        state_d = ST_FLUSH;
                        sr_d    = sr_shift;
                        sym_d   = par;
                        phase_d = '0;
                        tail_d  = '0;
                        last_d  = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        phase_d = '0;
                    end
                end
            end

            ST_FLUSH: begin
                if (out_fire) begin
                    if (phase_q != PHASE_LAST) begin
                        phase_d = phase_q + PW'(1);
                    end else if (tail_q == TAIL_LAST) begin
                        state_d = ST_IDLE;
                        phase_d = '0;
                    end else begin
                        sr_d    = sr_shift;
                        sym_d   = par;
                        phase_d = '0;
                        tail_d  = tail_q + TW'(1);
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered so they stay put while the sink stalls
        out_valid_d = (state_d != ST_IDLE);
        out_bit_d   = out_valid_d ? sym_d[phase_d] : 1'b0;
        out_last_d  = (state_d == ST_FLUSH) && (tail_d == TAIL_LAST) &&
                      (phase_d == PHASE_LAST);
    end

    // State registers; reset abandons any pending symbols and clears history
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            sr_q        <= '0;
            sym_q       <= '0;
            phase_q     <= '0;
            tail_q      <= '0;
            last_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            sym_q       <= sym_d;
            phase_q     <= phase_d;
            tail_q      <= tail_d;
            last_q      <= last_d;
            out_valid_q <= out_valid_d;
            out_bit_q   <= out_bit_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_bit   = out_bit_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_conv_encoder_par.sv
// Bench for conv_encoder_par: directed cases on the default K=3/N=2 code
// and randomized traffic on a K=5/N=3 code, both against a bit-history model.
module tb_conv_encoder_par;

    localparam int          KA = 3;
    localparam int          NA = 2;
    localparam int          KB = 5;
    localparam int          NB = 3;
    localparam logic [5:0]  GA = 6'b011_111;
    localparam logic [14:0] GB = 15'b01111_11101_10011;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] in_valid, in_ready, in_bit, in_last;
    logic [1:0] out_valid, out_ready, out_bit, out_last, busy;

    always #5 clock = ~clock;

    conv_encoder_par u_dut_a (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid[0]),
        .in_ready (in_ready[0]),
        .in_bit   (in_bit[0]),
        .in_last  (in_last[0]),
        .out_valid(out_valid[0]),
        .out_ready(out_ready[0]),
        .out_bit  (out_bit[0]),
        .out_last (out_last[0]),
        .busy     (busy[0])
    );

    conv_encoder_par #(
        .K(KB),
        .N(NB),
        .G(GB)
    ) u_dut_b (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid[1]),
        .in_ready (in_ready[1]),
        .in_bit   (in_bit[1]),
        .in_last  (in_last[1]),
        .out_valid(out_valid[1]),
        .out_ready(out_ready[1]),
        .out_bit  (out_bit[1]),
        .out_last (out_last[1]),
        .busy     (busy[1])
    );

    int total = 0;
    int bad   = 0;

    // Reference model: history of accepted bits (index 0 newest) and the
    // queue of expected {symbol, last} pairs still owed by the encoder
    int          cur_k;
    int          cur_n;
    logic [14:0] cur_g;
    bit          hist[$];
    logic [1:0]  expq[$];

    bit         src_bits[$];
    bit         src_last[$];
    bit         obs_bits[$];
    bit         obs_last[$];
    bit         rdy_log[$];
    bit         acc_s;
    logic       smp_ov, smp_ob, smp_ol, smp_ir;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < cur_k; i++) hist.push_back(1'b0);
        expq.delete();
    endtask

    task automatic select_dut(input int d);
        cur_k = (d == 0) ? KA : KB;
        cur_n = (d == 0) ? NA : NB;
        cur_g = (d == 0) ? 15'(GA) : GB;
        model_reset();
    endtask

    task automatic model_bit(input bit b, input bit mark_last);
        bit s;
        hist.push_front(b);
        void'(hist.pop_back());
        for (int j = 0; j < cur_n; j++) begin
            s = 1'b0;
            for (int i = 0; i < cur_k; i++) begin
                if (cur_g[j*cur_k + i] && hist[i]) s = ~s;
            end
            expq.push_back({s, mark_last && (j == cur_n - 1)});
        end
    endtask

    task automatic model_accept(input bit b, input bit l);
        model_bit(b, 1'b0);
        if (l) begin
            for (int t = 1; t < cur_k; t++) model_bit(1'b0, t == cur_k - 1);
        end
    endtask

    function automatic logic [31:0] pack_log(input int sel, input int n);
        logic [31:0] v;
        bit          b;
        v = '0;
        for (int i = 0; i < n; i++) begin
            b = (sel == 0) ? obs_bits[i] : (sel == 1) ? obs_last[i] : rdy_log[i];
            v = {v[30:0], b};
        end
        return v;
    endfunction

    task automatic clear_logs();
        obs_bits.delete();
        obs_last.delete();
        rdy_log.delete();
    endtask

    // One clock: sample at the falling edge, score handshakes, step to posedge+1
    task automatic tick(input int d);
        logic [1:0] e;
        @(negedge clock);
        smp_ov = out_valid[d];
        smp_ob = out_bit[d];
        smp_ol = out_last[d];
        smp_ir = in_ready[d];
        rdy_log.push_back(smp_ir);
        acc_s = in_valid[d] && smp_ir;
        if (smp_ov && out_ready[d]) begin
            obs_bits.push_back(smp_ob);
            obs_last.push_back(smp_ol);
            check_eq("sym_owed", 32'(expq.size() > 0), 32'd1);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                check_eq("sym_bit", 32'(smp_ob), 32'(e[1]));
                check_eq("sym_last", 32'(smp_ol), 32'(e[0]));
            end
        end
        if (acc_s) model_accept(in_bit[d], in_last[d]);
        @(posedge clock);
        #1;
    endtask

    task automatic drain_checks(input int d, input string tag, input bit timed_out);
        check_eq({tag, "_timeout"}, 32'(timed_out), 32'd0);
        check_eq({tag, "_owed"}, 32'(expq.size()), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy[d]), 32'd0);
    endtask

    // Present src_bits back to back with the sink always ready
    task automatic drive_src(input int d, input string tag);
        int idx = 0;
        int cyc = 0;
        while ((idx < src_bits.size() || busy[d] || expq.size() != 0) && cyc < 500) begin
            in_valid[d]  = (idx < src_bits.size());
            in_bit[d]    = in_valid[d] ? src_bits[idx] : 1'($urandom);
            in_last[d]   = in_valid[d] ? src_last[idx] : 1'($urandom);
            out_ready[d] = 1'b1;
            tick(d);
            if (acc_s) idx++;
            cyc++;
        end
        in_valid[d] = 1'b0;
        drain_checks(d, tag, cyc >= 500);
    endtask

    // Random valid/ready/last traffic; bit values are scrambled every cycle so
    // anything sampled outside a real accept corrupts the stream
    task automatic drive_random(input int d, input int nbits, input int vpct,
                                input int rpct, input int lpct, input string tag);
        int cnt = 0;
        int cyc = 0;
        while ((cnt < nbits || busy[d] || expq.size() != 0) && cyc < 20000) begin
            in_valid[d] = (cnt < nbits) && ($urandom_range(99) < vpct);
            in_bit[d]   = 1'($urandom);
            if (in_valid[d])
                in_last[d] = (cnt == nbits - 1) || ($urandom_range(99) < lpct);
            else
                in_last[d] = 1'($urandom);
            out_ready[d] = ($urandom_range(99) < rpct);
            tick(d);
            if (acc_s) cnt++;
            cyc++;
        end
        in_valid[d]  = 1'b0;
        out_ready[d] = 1'b0;
        drain_checks(d, tag, cyc >= 20000);
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = '0;
        in_bit    = '0;
        in_last   = '0;
        out_ready = '0;
        select_dut(0);
        repeat (3) @(posedge clock);
        #1;

        // Reset state, with in_valid offered to show in_ready stays low
        in_valid = 2'b11;
        #1;
        check_eq("rst_ready", 32'(in_ready), 32'd0);
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_bit", 32'(out_bit), 32'd0);
        check_eq("rst_last", 32'(out_last), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        in_valid = 2'b00;
        reset = 1'b1;
        @(posedge clock);
        #1;
        check_eq("idle_ready", 32'(in_ready), 32'd3);

        // Terminated block 1,0,1
        clear_logs();
        src_bits = '{1'b1, 1'b0, 1'b1};
        src_last = '{1'b0, 1'b0, 1'b1};
        drive_src(0, "blk101");
        check_eq("blk101_count", 32'(obs_bits.size()), 32'd10);
        check_eq("blk101_bits", pack_log(0, 10), 32'b1111011110);
        check_eq("blk101_lasts", pack_log(1, 10), 32'b0000000001);

        // Continuous stream 1,1,1,1 without flush
        clear_logs();
        src_bits = '{1'b1, 1'b1, 1'b1, 1'b1};
        src_last = '{1'b0, 1'b0, 1'b0, 1'b0};
        drive_src(0, "stream");
        check_eq("stream_count", 32'(obs_bits.size()), 32'd8);
        check_eq("stream_bits", pack_log(0, 8), 32'b11001010);
        check_eq("stream_lasts", pack_log(1, 8), 32'd0);
        check_eq("stream_ready", pack_log(2, 8), 32'b10101010);

        // Sink stall of 5 cycles on the second symbol
        clear_logs();
        in_valid[0] = 1'b1; in_bit[0] = 1'b1; in_last[0] = 1'b0; out_ready[0] = 1'b1;
        tick(0);
        check_eq("stall_accept", 32'(acc_s), 32'd1);
        check_eq("stall_lat0", 32'(smp_ov), 32'd0);
        in_valid[0] = 1'b0;
        tick(0);
        check_eq("stall_lat1", 32'(smp_ov), 32'd1);
        for (int c = 0; c < 5; c++) begin
            in_valid[0]  = 1'b1;
            in_bit[0]    = 1'($urandom);
            in_last[0]   = 1'($urandom);
            out_ready[0] = 1'b0;
            tick(0);
            check_eq("stall_valid", 32'(smp_ov), 32'd1);
            check_eq("stall_ready", 32'(smp_ir), 32'd0);
            check_eq("stall_hold", 32'(smp_ob), 32'(expq[0][1]));
        end
        in_valid[0] = 1'b0;
        out_ready[0] = 1'b1;
        tick(0);
        src_bits.delete();
        src_last.delete();
        drive_src(0, "stall");
        check_eq("stall_count", 32'(obs_bits.size()), 32'd2);

        // Random valid toggling with junk data while not ready
        drive_random(0, 300, 50, 60, 10, "randa");

        // Reset asserted mid-flush, then a fresh block from the zero state
        in_valid[0] = 1'b1; in_bit[0] = 1'b1; in_last[0] = 1'b1; out_ready[0] = 1'b1;
        tick(0);
        in_valid[0] = 1'b0;
        tick(0);
        tick(0);
        check_eq("flush_busy", 32'(busy[0]), 32'd1);
        check_eq("flush_valid", 32'(out_valid[0]), 32'd1);
        in_valid[0] = 1'b1;
        reset = 1'b0;
        #1;
        check_eq("midrst_valid", 32'(out_valid[0]), 32'd0);
        check_eq("midrst_bit", 32'(out_bit[0]), 32'd0);
        check_eq("midrst_last", 32'(out_last[0]), 32'd0);
        check_eq("midrst_busy", 32'(busy[0]), 32'd0);
        check_eq("midrst_ready", 32'(in_ready[0]), 32'd0);
        in_valid[0] = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        clear_logs();
        src_bits = '{1'b1};
        src_last = '{1'b0};
        drive_src(0, "postrst");
        check_eq("postrst_count", 32'(obs_bits.size()), 32'd2);
        check_eq("postrst_bits", pack_log(0, 2), 32'b11);

        // K=5, N=3 code with 1000 random bits
        select_dut(1);
        drive_random(1, 1000, 70, 70, 5, "randb");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
